// File: rtl/link_table_order_queue.sv
// link_table_order_queue: FIFO front-end issuing host orders to the link-table manager; optional LINK_TABLE_QUEUE_STAT_EN adds stat counters
module link_table_order_queue #(
  parameter int ADDR_WIDTH  = 16,
  parameter int DATA_WIDTH  = 16,
  parameter int TABLE_WIDTH = 8,
  parameter int DEPTH       = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   host_valid,
  output logic                   host_busy,
  input  logic [1:0]             host_type,
  input  logic [TABLE_WIDTH-1:0] host_table,
  input  logic [ADDR_WIDTH-1:0]  host_node,
  input  logic [DATA_WIDTH-1:0]  host_data,
  output logic                   order_valid,
  input  logic                   order_busy,
  output logic [1:0]             order_type,
  output logic [TABLE_WIDTH-1:0] order_table,
  output logic [ADDR_WIDTH-1:0]  order_node,
  output logic [DATA_WIDTH-1:0]  order_data,
  input  logic                   dout_valid,
  output logic                   dout_busy,
  input  logic [DATA_WIDTH-1:0]  dout_data,
  output logic                   resp_valid,
  input  logic                   resp_busy,
  output logic [1:0]             resp_type,
  output logic [DATA_WIDTH-1:0]  resp_data,
  output logic                   resp_fail
`ifdef LINK_TABLE_QUEUE_STAT_EN
  ,
  output logic [15:0]            stat_issued,
  output logic [15:0]            stat_failed
`endif
);
  localparam int PW = $clog2(DEPTH);
  localparam int EW = 2 + TABLE_WIDTH + ADDR_WIDTH + DATA_WIDTH;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  state_t                 r_state, w_next;
  logic [EW-1:0]          r_mem [DEPTH];
  logic [PW:0]            r_wptr, r_rptr;
  logic                   w_full, w_empty, w_push, w_pop, w_reject;
  logic [1:0]             w_head_type;
  logic [TABLE_WIDTH-1:0] w_head_table;
  logic [ADDR_WIDTH-1:0]  w_head_node;
  logic [DATA_WIDTH-1:0]  w_head_data;
  logic                   r_order_valid, r_dout_busy, r_resp_valid, r_resp_fail;
  logic [1:0]             r_type;
  logic [TABLE_WIDTH-1:0] r_table;
  logic [ADDR_WIDTH-1:0]  r_node;
  logic [DATA_WIDTH-1:0]  r_data, r_resp_data;
  assign w_full  = (r_wptr[PW] != r_rptr[PW]) && (r_wptr[PW-1:0] == r_rptr[PW-1:0]);
  assign w_empty = r_wptr == r_rptr;
  assign w_push  = host_valid && !w_full;
  assign w_pop   = (r_state == IDLE) && !w_empty;
  assign {w_head_type, w_head_table, w_head_node, w_head_data} = r_mem[r_rptr[PW-1:0]];
  assign w_reject = !w_head_type[1] && (w_head_node == '0);
  assign host_busy   = w_full;
  assign order_valid = r_order_valid;
  assign order_type  = r_type;
  assign order_table = r_table;
  assign order_node  = r_node;
  assign order_data  = r_data;
  assign dout_busy   = r_dout_busy;
  assign resp_valid  = r_resp_valid;
  assign resp_type   = r_type;
  assign resp_data   = r_resp_data;
  assign resp_fail   = r_resp_fail;
  // FIFO storage: written on every accepted host order, never reset
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr[PW-1:0]] <= {host_type, host_table, host_node, host_data};
  end
  // FIFO pointers; full is judged before this cycle's pop, so a pop never frees a slot for the same-cycle push
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + (PW+1)'(1);
      if (w_pop) r_rptr <= r_rptr + (PW+1)'(1);
    end
  end
  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else r_state <= w_next;
  end
  // FSM next state: one order outstanding, rejected orders go straight to the response
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (!w_empty) w_next = w_reject ? RESP : ISSUE;
      ISSUE:   if (!order_busy) w_next = WAIT;
      WAIT:    if (dout_valid && !r_dout_busy) w_next = RESP;
      RESP:    if (!resp_busy) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end
  // Registered order/response outputs driven per FSM state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_order_valid <= 1'b0;
      r_dout_busy   <= 1'b1;
      r_resp_valid  <= 1'b0;
      r_resp_fail   <= 1'b0;
      r_resp_data   <= '0;
      r_type        <= '0;
      r_table       <= '0;
      r_node        <= '0;
      r_data        <= '0;
    end else begin
      case (r_state)
        IDLE: if (!w_empty) begin
          {r_type, r_table, r_node, r_data} <= {w_head_type, w_head_table, w_head_node, w_head_data};
          if (w_reject) begin
            r_resp_valid <= 1'b1;
            r_resp_fail  <= 1'b1;
            r_resp_data  <= '0;
          end else r_order_valid <= 1'b1;
        end
        ISSUE: if (!order_busy) begin
          r_order_valid <= 1'b0;
          r_dout_busy   <= 1'b0;
        end
        WAIT: if (dout_valid && !r_dout_busy) begin
          r_dout_busy  <= 1'b1;
          r_resp_data  <= dout_data;
          r_resp_fail  <= (r_type != 2'b11) && (dout_data == '0);
          r_resp_valid <= 1'b1;
        end
        RESP: if (!resp_busy) r_resp_valid <= 1'b0;
        default: ;
      endcase
    end
  end
`ifdef LINK_TABLE_QUEUE_STAT_EN
  logic [15:0] r_stat_issued, r_stat_failed;
  assign stat_issued = r_stat_issued;
  assign stat_failed = r_stat_failed;
  // Saturating counters of manager order transfers and failed response transfers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stat_issued <= '0;
      r_stat_failed <= '0;
    end else begin
      if (r_order_valid && !order_busy && r_stat_issued != 16'hFFFF) r_stat_issued <= r_stat_issued + 16'd1;
      if (r_resp_valid && !resp_busy && r_resp_fail && r_stat_failed != 16'hFFFF) r_stat_failed <= r_stat_failed + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_link_table_order_queue.sv
// tb_link_table_order_queue: scoreboard bench with a manager stub for link_table_order_queue
module tb_link_table_order_queue;
  localparam int AW = 16;
  localparam int DW = 16;
  localparam int TW = 8;
  logic clk = 0, rst_n = 0, host_valid = 0, order_busy = 0, resp_busy = 0, dout_valid = 0;
  logic [1:0] host_type = 0;
  logic [TW-1:0] host_table = 0;
  logic [AW-1:0] host_node = 0;
  logic [DW-1:0] host_data = 0, dout_data = 0;
  logic host_busy, order_valid, dout_busy, resp_valid, resp_fail;
  logic [1:0] order_type, resp_type;
  logic [TW-1:0] order_table;
  logic [AW-1:0] order_node;
  logic [DW-1:0] order_data, resp_data;
`ifdef LINK_TABLE_QUEUE_STAT_EN
  logic [15:0] stat_issued, stat_failed;
`endif
  int n_cmp = 0, n_err = 0, n_issued = 0, dly = 0, cnt = 0, base = 0;
  logic [18:0] exp_q[$];
  logic [41:0] ord_q[$];
  logic [DW-1:0] ret_q[$];
  logic [DW-1:0] pend_data = 0;
  bit s_ord, s_dout, pend, ov_seen;

  link_table_order_queue #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TABLE_WIDTH(TW), .DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .host_valid(host_valid), .host_busy(host_busy), .host_type(host_type),
    .host_table(host_table), .host_node(host_node), .host_data(host_data),
    .order_valid(order_valid), .order_busy(order_busy), .order_type(order_type),
    .order_table(order_table), .order_node(order_node), .order_data(order_data),
    .dout_valid(dout_valid), .dout_busy(dout_busy), .dout_data(dout_data),
    .resp_valid(resp_valid), .resp_busy(resp_busy), .resp_type(resp_type),
    .resp_data(resp_data), .resp_fail(resp_fail)
`ifdef LINK_TABLE_QUEUE_STAT_EN
    , .stat_issued(stat_issued), .stat_failed(stat_failed)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Sample handshakes mid-cycle; check issued orders and returned responses against the scoreboard
  always @(negedge clk) begin
    s_ord  = rst_n && order_valid && !order_busy;
    s_dout = rst_n && dout_valid && !dout_busy;
    if (order_valid) ov_seen = 1;
    if (s_ord) begin
      n_issued++;
      chk("order present", 64'(ord_q.size() != 0), 1);
      if (ord_q.size() != 0) begin
        chk("order fields", {order_type, order_table, order_node, order_data}, ord_q.pop_front());
        pend_data = ret_q.pop_front();
      end
    end
    if (rst_n && resp_valid && !resp_busy) begin
      chk("resp present", 64'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) chk("resp type/data/fail", {resp_type, resp_data, resp_fail}, exp_q.pop_front());
    end
  end

  // Manager stub: returns the queued result dly cycles after each order transfer
  always begin
    @(posedge clk);
    #2;
    if (!rst_n) begin
      dout_valid = 0;
      pend = 0;
    end else begin
      if (s_dout) dout_valid = 0;
      if (s_ord) begin
        pend = 1;
        cnt = dly;
      end
      if (pend) begin
        if (cnt == 0) begin
          dout_valid = 1;
          dout_data = pend_data;
          pend = 0;
        end else cnt--;
      end
    end
  end

  task automatic push(input logic [1:0] t, input logic [TW-1:0] tb, input logic [AW-1:0] n,
                      input logic [DW-1:0] d, input logic [DW-1:0] r);
    int k = 0;
    tick();
    host_valid = 1;
    host_type = t;
    host_table = tb;
    host_node = n;
    host_data = d;
    @(negedge clk);
    while (host_busy && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("host accept", 64'(host_busy), 0);
    if (!t[1] && n == 0) exp_q.push_back({t, {DW{1'b0}}, 1'b1});
    else begin
      ord_q.push_back({t, tb, n, d});
      ret_q.push_back(r);
      exp_q.push_back({t, r, (t != 2'b11) && (r == 0)});
    end
    tick();
    host_valid = 0;
  endtask

  task automatic drain();
    int k = 0;
    while ((exp_q.size() != 0 || ord_q.size() != 0) && k < 300) begin
      @(negedge clk);
      k++;
    end
    chk("drain", 64'(exp_q.size() + ord_q.size()), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    repeat (3) tick();
    @(negedge clk);
    chk("rst order_valid", 64'(order_valid), 0);
    chk("rst resp_valid", 64'(resp_valid), 0);
    chk("rst host_busy", 64'(host_busy), 0);
    chk("rst dout_busy", 64'(dout_busy), 1);
    chk("rst data outs", {order_type, order_table, order_node, order_data, resp_type, resp_data, resp_fail}, 0);
    tick();
    rst_n = 1;
    push(2'b11, 8'd3, 16'd2, 16'h1234, 16'h00A5);
    @(negedge clk);
    chk("read order_valid N+1", 64'(order_valid), 0);
    @(negedge clk);
    chk("read order_valid N+2", 64'(order_valid), 1);
    @(negedge clk);
    chk("read dout_busy N+3", 64'(dout_busy), 0);
    drain();
    chk("read issued once", 64'(n_issued), 1);
    ov_seen = 0;
    push(2'b00, 8'd1, 16'd0, 16'hBEEF, 16'h0);
    @(negedge clk);
    chk("reject resp_valid N+1", 64'(resp_valid), 0);
    @(negedge clk);
    chk("reject resp_valid N+2", 64'(resp_valid), 1);
    drain();
    chk("reject never issued", 64'(ov_seen), 0);
    chk("reject issue count", 64'(n_issued), 1);
    tick();
    order_busy = 1;
    push(2'b11, 8'd1, 16'd10, 16'h0, 16'h1111);
    repeat (3) tick();
    push(2'b10, 8'd1, 16'd11, 16'h5555, 16'h0000);
    push(2'b01, 8'd1, 16'd5, 16'h0, 16'h0001);
    push(2'b00, 8'd2, 16'd0, 16'h0007, 16'h0);
    push(2'b11, 8'd2, 16'd12, 16'h0, 16'h0000);
    @(negedge clk);
    chk("full host_busy", 64'(host_busy), 1);
    chk("stalled order_valid", 64'(order_valid), 1);
    fork
      begin
        repeat (8) tick();
        order_busy = 0;
      end
    join_none
    push(2'b00, 8'd2, 16'd7, 16'h0009, 16'h2222);
    drain();
    chk("stall issue count", 64'(n_issued), 6);
    tick();
    resp_busy = 1;
    push(2'b11, 8'd4, 16'd3, 16'h0, 16'h00C3);
    push(2'b10, 8'd4, 16'd4, 16'h0001, 16'h0005);
    k = 0;
    while (!resp_valid && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("backpressure resp_valid", 64'(resp_valid), 1);
    repeat (10) begin
      @(negedge clk);
      chk("backpressure hold", {resp_valid, resp_type, resp_data, resp_fail, dout_busy, order_valid},
          {1'b1, 2'b11, 16'h00C3, 1'b0, 1'b1, 1'b0});
    end
    tick();
    resp_busy = 0;
    drain();
    tick();
    dly = 20;
    push(2'b11, 8'd5, 16'd6, 16'h0, 16'h0077);
    k = 0;
    while (dout_busy && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("reached wait", 64'(dout_busy), 0);
    tick();
    rst_n = 0;
    exp_q.delete();
    ord_q.delete();
    ret_q.delete();
    @(negedge clk);
    chk("mid reset order_valid", 64'(order_valid), 0);
    chk("mid reset resp_valid", 64'(resp_valid), 0);
    chk("mid reset dout_busy", 64'(dout_busy), 1);
    chk("mid reset host_busy", 64'(host_busy), 0);
    tick();
    rst_n = 1;
    dly = 0;
    base = n_issued;
    ov_seen = 0;
    repeat (4) @(negedge clk);
    chk("fifo empty after reset", 64'(ov_seen), 0);
    push(2'b11, 8'd5, 16'd8, 16'h0, 16'h0099);
    drain();
    chk("post reset issue count", 64'(n_issued - base), 1);
`ifdef LINK_TABLE_QUEUE_STAT_EN
    chk("stat_issued", 64'(stat_issued), 64'(n_issued - base));
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
